// File: rtl/stopwatch_action_ctrl_if.sv
// Button/status bundle between the board push buttons and the stopwatch
// action controller. The master side is the board (drives raw active-low
// buttons, observes status); the slave side is the controller.
interface stopwatch_action_ctrl_if;
  logic       btn_clear;
  logic       btn_start_pause;
  logic       btn_hold;
  logic       running;
  logic       clk_work;
  logic       display;
  logic       clear_pulse;
  logic [1:0] state;

  modport master (
    output btn_clear,
    output btn_start_pause,
    output btn_hold,
    input  running,
    input  clk_work,
    input  display,
    input  clear_pulse,
    input  state
  );

  modport slave (
    input  btn_clear,
    input  btn_start_pause,
    input  btn_hold,
    output running,
    output clk_work,
    output display,
    output clear_pulse,
    output state
  );
endinterface

// File: rtl/stopwatch_action_ctrl.sv
// Stopwatch action controller: synchronises and debounces three raw
// active-low buttons, turns debounced presses into one-cycle events and
// drives a three-state watch FSM (IDLE/RUN/PAUSE) plus a display-freeze flag.
// Optional macro STOPWATCH_LONG_PRESS_CLEAR_EN: a long hold of start/pause
// issues a clear instead, and a short start/pause acts on release.
module stopwatch_action_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int DB_W              = 20,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int LP_W              = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  stopwatch_action_ctrl_if.slave bus
);

  // Button lane indices used throughout.
  localparam int BTN_CLEAR = 0;
  localparam int BTN_SP    = 1;
  localparam int BTN_HOLD  = 2;
  localparam int NUM_BTN   = 3;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Counter widths must hold their terminal counts; catch bad overrides early.
  if (DEBOUNCE_CYCLES < 1 || (64'(1) << DB_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_db_w
    $error("DB_W cannot hold DEBOUNCE_CYCLES");
  end
  if (LONG_PRESS_CYCLES < 1 || (64'(1) << LP_W) <= 64'(LONG_PRESS_CYCLES)) begin : g_bad_lp_w
    $error("LP_W cannot hold LONG_PRESS_CYCLES");
  end

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] db_level;   // debounced level, 1 = released
  logic [NUM_BTN-1:0] db_prev;    // debounced level one cycle earlier
  logic [NUM_BTN-1:0] press_evt;  // one-cycle pulse on debounced 1->0

  assign btn_raw[BTN_CLEAR] = bus.btn_clear;
  assign btn_raw[BTN_SP]    = bus.btn_start_pause;
  assign btn_raw[BTN_HOLD]  = bus.btn_hold;

  // One identical synchroniser + debouncer + press detector per button.
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic            sync1_reg;
    logic            sync2_reg;
    logic            db_reg;
    logic            db_d_reg;
    logic            press_reg;
    logic [DB_W-1:0] cnt_reg;

    // Two-flop synchroniser, debounce counter and registered press edge.
    always_ff @(posedge clk) begin
      if (!reset) begin
        sync1_reg <= 1'b1;
        sync2_reg <= 1'b1;
        db_reg    <= 1'b1;
        db_d_reg  <= 1'b1;
        press_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= btn_raw[gi];
        sync2_reg <= sync1_reg;
        db_d_reg  <= db_reg;
        press_reg <= db_d_reg & ~db_reg;
        if (sync2_reg == db_reg) begin
          // Levels agree: any partial count was a glitch, forget it.
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          // Differed for DEBOUNCE_CYCLES consecutive samples: accept.
          db_reg  <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end
    end

    assign db_level[gi]  = db_reg;
    assign db_prev[gi]   = db_d_reg;
    assign press_evt[gi] = press_reg;
  end

  logic clr_evt;
  logic sp_evt;
  logic hold_evt;

  assign hold_evt = press_evt[BTN_HOLD];

`ifdef STOPWATCH_LONG_PRESS_CLEAR_EN
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt_reg;
  logic            lp_done_reg;
  logic            lp_sp_reg;
  logic            lp_clr_reg;

  // Time the debounced start/pause low level: a long hold becomes a clear
  // (fired once), a short hold becomes start/pause on the release edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lp_cnt_reg  <= '0;
      lp_done_reg <= 1'b0;
      lp_sp_reg   <= 1'b0;
      lp_clr_reg  <= 1'b0;
    end else begin
      lp_sp_reg  <= 1'b0;
      lp_clr_reg <= 1'b0;
      if (!db_level[BTN_SP]) begin
        if (!lp_done_reg) begin
          if (lp_cnt_reg == LP_LAST) begin
            lp_clr_reg  <= 1'b1;
            lp_done_reg <= 1'b1;
            lp_cnt_reg  <= '0;
          end else begin
            lp_cnt_reg <= lp_cnt_reg + LP_W'(1);
          end
        end
      end else begin
        // Debounced release edge: short press acts now, long press is spent.
        if (!db_prev[BTN_SP] && !lp_done_reg) begin
          lp_sp_reg <= 1'b1;
        end
        lp_cnt_reg  <= '0;
        lp_done_reg <= 1'b0;
      end
    end
  end

  assign clr_evt = press_evt[BTN_CLEAR] | lp_clr_reg;
  assign sp_evt  = lp_sp_reg;
`else
  assign clr_evt = press_evt[BTN_CLEAR];
  assign sp_evt  = press_evt[BTN_SP];
`endif

  state_t state_reg;
  logic   running_reg;
  logic   display_reg;
  logic   clear_pulse_reg;

  // Watch FSM with registered outputs; clear > start_pause > hold, and the
  // losers of a same-cycle collision are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      running_reg     <= 1'b0;
      display_reg     <= 1'b1;
      clear_pulse_reg <= 1'b0;
    end else begin
      clear_pulse_reg <= 1'b0;
      if (clr_evt) begin
        state_reg       <= ST_IDLE;
        running_reg     <= 1'b0;
        display_reg     <= 1'b1;
        clear_pulse_reg <= 1'b1;
      end else if (sp_evt) begin
        case (state_reg)
          ST_RUN: begin
            state_reg   <= ST_PAUSE;
            running_reg <= 1'b0;
          end
          default: begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        endcase
      end else if (hold_evt && state_reg != ST_IDLE) begin
        display_reg <= ~display_reg;
      end
    end
  end

  assign bus.state       = state_reg;
  assign bus.running     = running_reg;
  assign bus.clk_work    = running_reg;
  assign bus.display     = display_reg;
  assign bus.clear_pulse = clear_pulse_reg;

endmodule

// File: doc/stopwatch_action_ctrl.md
Name: stopwatch_action_ctrl

Overview:
- Clocked successor to the stopwatch button-action block: turns raw active-low push buttons into clean control signals for the stopwatch controller and display.
- Each button gets a 2-FF synchroniser and a parametrised debouncer; debounced presses drive a 3-state watch FSM and a display-freeze toggle.
- Issues a one-cycle clear pulse to the time counters.
- Sits between the board buttons and the stopwatch counter/display datapath.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a button level change (10 ms at 50 MHz).
DB_W, 20, debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
LONG_PRESS_CYCLES, 100000000, debounced-low hold time that counts as a long press (used only with the optional feature).
LP_W, 27, long-press counter width; must satisfy 2^LP_W > LONG_PRESS_CYCLES.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-low system reset.
btn_clear  input  1  raw active-low button: clear the watch.
btn_start_pause  input  1  raw active-low button: start / pause.
btn_hold  input  1  raw active-low button: freeze / unfreeze the display.
running  output  1  1 while the watch counts.
clk_work  output  1  counter enable to the time counter; always equals running.
display  output  1  1 = display follows the live time; 0 = display frozen.
clear_pulse  output  1  one-cycle pulse that zeroes the time counters.
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, running=0, clk_work=0, display=1, clear_pulse=0.
  - Synchronisers and debounced levels forced to 1 (released); all counters 0.
  - Reset wins over every button event in the same cycle.
- Synchroniser: 2 flops per button.
- Debouncer, per button:
  - Counter increments while the synchronised level differs from the debounced level; it returns to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- Press event: one-cycle registered pulse when the debounced level goes 1->0. Release generates nothing, except as described under Optional Feature.
- Latency: a clean press first sampled low at edge t updates the FSM outputs at edge t+DEBOUNCE_CYCLES+3.
- FSM transitions:
  - IDLE: start_pause -> RUN.
  - RUN: start_pause -> PAUSE.
  - PAUSE: start_pause -> RUN.
  - Any state: clear -> IDLE, with display forced to 1 and clear_pulse=1 for exactly one cycle.
- clear in IDLE still issues clear_pulse.
- hold event toggles display in RUN and PAUSE; it is ignored in IDLE, where display stays 1.
- Simultaneous events in one cycle: priority is clear > start_pause > hold. Lower-priority events in that cycle are discarded, not queued.
- running = (state==RUN). All outputs are registered; there are no combinational paths from buttons to outputs.
- Holding a button produces exactly one press event; a new event requires a debounced release first.

Optional Feature:
- Macro: STOPWATCH_LONG_PRESS_CLEAR_EN.
- Defined:
  - start_pause timing is measured from its debounced low level.
  - If released before LONG_PRESS_CYCLES cycles, the start_pause event fires on the debounced release edge.
  - If held for LONG_PRESS_CYCLES cycles, a clear event fires once at that cycle, and the later release produces nothing.
  - btn_clear keeps working unchanged.
- Undefined: start_pause acts on the debounced press edge as described under Behaviour; the long-press counter and logic are absent.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
- Assert reset=0 for 2 cycles with all buttons high -> state=00, running=0, clk_work=0, display=1, clear_pulse=0.
- btn_start_pause low from edge 10 and held -> state=01 and running=1 at edge 17; holding 30 more cycles -> no further change. Release then press again -> state=10, running=0.
- btn_start_pause low for 3 cycles only (glitch), and separately a 1-cycle high blip during a held press -> no state change from the glitch; the held press still yields exactly one event.
- In RUN, press btn_hold -> display=0. Press again -> display=1. In IDLE, btn_hold press -> display stays 1.
- In RUN with display=0, press btn_clear and btn_start_pause in the same cycle -> state=00, display=1, clear_pulse high for exactly 1 cycle, start_pause discarded. Assert reset mid-debounce -> the pending press is lost.
- With STOPWATCH_LONG_PRESS_CLEAR_EN:
  - Hold start_pause for 25 debounced cycles from RUN -> one clear_pulse at cycle 20, state=00, no event on release.
  - Hold start_pause for 10 cycles -> state toggles at the release edge.
